// File: rtl/wfg_pkg.sv
// Shared types and constants for the WFG step sequencer and its step table.
package wfg_pkg;

  localparam int FUNC_W      = 3;
  localparam int PHASE_W     = 8;
  // Widest dwell field an entry view can carry; DWELL_W must not exceed it.
  localparam int DWELL_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_DONE
  } seq_state_t;

  // Decoded view of one table entry.
  typedef struct packed {
    logic [FUNC_W-1:0]      func;
    logic [PHASE_W-1:0]     phase;
    logic [DWELL_W_MAX-1:0] dwell;
  } step_entry_t;

  // Counter reload for a step: a dwell of 0 behaves like 1, so the step
  // always lasts max(dwell,1) cycles including its load cycle.
  function automatic logic [DWELL_W_MAX-1:0] dwell_reload(input logic [DWELL_W_MAX-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - DWELL_W_MAX'(1);
  endfunction

endpackage

// File: rtl/wfg_step_ram.sv
// Step table: DEPTH register rows, one write port, combinational read port,
// every row cleared by reset.
module wfg_step_ram
  import wfg_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = FUNC_W + PHASE_W + 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] rows [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
      logic [WIDTH-1:0] row_reg;

      // Each row captures write data only when addressed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_reg <= '0;
        end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
          row_reg <= wr_data;
        end
      end

      assign rows[gi] = row_reg;
    end
  endgenerate

  assign rd_data = rows[rd_addr];

endmodule

// File: rtl/wfg_sequencer.sv
// Step sequencer that plays a table of {func, phase, dwell} entries into a
// WFG_DDS instance, issuing one dds_ld pulse per step.
module wfg_sequencer
  import wfg_pkg::*;
#(
  parameter int STEPS   = 8,
  parameter int DWELL_W = 16,
  parameter int ADDR_W  = $clog2(STEPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [FUNC_W-1:0]   wr_func,
  input  logic [PHASE_W-1:0]  wr_phase,
  input  logic [DWELL_W-1:0]  wr_dwell,
  input  logic [ADDR_W-1:0]   last_step,
  input  logic                loop_en,
  input  logic                start,
  input  logic                stop,
  output logic [FUNC_W-1:0]   func,
  output logic [PHASE_W-1:0]  phaseControll,
  output logic                dds_ld,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   step_idx
);

  localparam int ENTRY_W = FUNC_W + PHASE_W + DWELL_W;

  seq_state_t         state_reg, state_next;
  logic [ADDR_W-1:0]  step_idx_reg, step_idx_next;
  logic [ADDR_W-1:0]  last_reg, last_next;
  logic               loop_reg, loop_next;
  logic [DWELL_W-1:0] cnt_reg, cnt_next;
  logic [FUNC_W-1:0]  func_reg, func_next;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic               dds_ld_reg, dds_ld_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic [ADDR_W-1:0]  adv_idx;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  step_entry_t        rd_entry;
  logic               ram_we;
  logic               do_load;

  // The table may only change while idle, so a run always sees a stable table.
  assign ram_we = wr_en && (state_reg == ST_IDLE);

  wfg_step_ram #(
    .DEPTH  (STEPS),
    .WIDTH  (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_step_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_data ({wr_func, wr_phase, wr_dwell}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign rd_entry = '{
    func:  rd_data[ENTRY_W-1 -: FUNC_W],
    phase: rd_data[DWELL_W +: PHASE_W],
    dwell: DWELL_W_MAX'(rd_data[DWELL_W-1:0])
  };

  // Step after the current one: wraps to 0 past last_q (natural modulo-STEPS
  // increment otherwise). The table is read at the step about to be loaded,
  // so the entry lands in the output registers on the same edge.
  assign adv_idx = (step_idx_reg == last_reg) ? '0 : step_idx_reg + ADDR_W'(1);
  assign rd_addr = (state_reg == ST_IDLE) ? '0 : adv_idx;

  // Next-state and registered-output logic; do_load marks entry into LOAD.
  always_comb begin
    state_next    = state_reg;
    step_idx_next = step_idx_reg;
    last_next     = last_reg;
    loop_next     = loop_reg;
    cnt_next      = cnt_reg;
    func_next     = func_reg;
    phase_next    = phase_reg;
    dds_ld_next   = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    do_load       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!stop && start) begin
          last_next     = last_step;
          loop_next     = loop_en;
          step_idx_next = '0;
          do_load       = 1'b1;
        end
      end

      ST_LOAD, ST_DWELL: begin
        if (stop) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else if (cnt_reg == '0) begin
          if ((step_idx_reg != last_reg) || loop_reg) begin
            step_idx_next = adv_idx;
            do_load       = 1'b1;
          end else begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end
        end else begin
          state_next = ST_DWELL;
          cnt_next   = cnt_reg - DWELL_W'(1);
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase

    if (do_load) begin
      state_next  = ST_LOAD;
      func_next   = rd_entry.func;
      phase_next  = rd_entry.phase;
      dds_ld_next = 1'b1;
      busy_next   = 1'b1;
      cnt_next    = DWELL_W'(dwell_reload(rd_entry.dwell));
    end
  end

  // State, counter and output registers; reset aborts any run at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      step_idx_reg <= '0;
      last_reg     <= '0;
      loop_reg     <= 1'b0;
      cnt_reg      <= '0;
      func_reg     <= '0;
      phase_reg    <= '0;
      dds_ld_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      step_idx_reg <= step_idx_next;
      last_reg     <= last_next;
      loop_reg     <= loop_next;
      cnt_reg      <= cnt_next;
      func_reg     <= func_next;
      phase_reg    <= phase_next;
      dds_ld_reg   <= dds_ld_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign func          = func_reg;
  assign phaseControll = phase_reg;
  assign dds_ld        = dds_ld_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign step_idx      = step_idx_reg;

endmodule

// File: tb/tb_wfg_sequencer.sv
// Scoreboard bench for wfg_sequencer: runs are planned from the table model
// as a list of timed load/done events; a monitor pops and checks them.
module tb_wfg_sequencer;

  localparam int STEPS   = 8;
  localparam int DWELL_W = 16;
  localparam int ADDR_W  = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic [ADDR_W-1:0]  wr_addr = '0;
  logic [2:0]         wr_func = '0;
  logic [7:0]         wr_phase = '0;
  logic [DWELL_W-1:0] wr_dwell = '0;
  logic [ADDR_W-1:0]  last_step = '0;
  logic               loop_en = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [2:0]         func;
  logic [7:0]         phaseControll;
  logic               dds_ld;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  step_idx;

  wfg_sequencer #(.STEPS(STEPS), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_func(wr_func), .wr_phase(wr_phase), .wr_dwell(wr_dwell),
    .last_step(last_step), .loop_en(loop_en), .start(start), .stop(stop),
    .func(func), .phaseControll(phaseControll), .dds_ld(dds_ld),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
    int f;
    int p;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  busy_from = 0;
  int  busy_to = 0;
  int  m_func[STEPS];
  int  m_phase[STEPS];
  int  m_dwell[STEPS];
  int  t0, done_cyc, stop_cyc;
  int  last_f, last_p, last_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy window every cycle, and one popped event per dds_ld/done.
  always @(negedge clk) begin : monitor
    ev_t e;
    check("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc < busy_to)));
    if (dds_ld === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({dds_ld, done}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(done), 32'(e.is_done));
        check("event_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.is_done) begin
          check("ld_func", 32'(func), 32'(e.f));
          check("ld_phase", 32'(phaseControll), 32'(e.p));
          check("ld_idx", 32'(step_idx), 32'(e.idx));
          $display("ld   cyc=%0d idx=%0d func=%0d phase=%0d", cyc, step_idx, func, phaseControll);
        end else begin
          $display("done cyc=%0d", cyc);
        end
      end
    end
  end

  // Expected events from the table model: step i lasts max(dwell_i,1) cycles.
  task automatic plan(input int last, input bit lp, input int cutoff);
    int c;
    int i;
    c = t0;
    i = 0;
    done_cyc = -1;
    while (c <= cutoff) begin
      exp_q.push_back('{0, c, m_func[i], m_phase[i], i});
      last_f = m_func[i];
      last_p = m_phase[i];
      last_i = i;
      c += (m_dwell[i] == 0) ? 1 : m_dwell[i];
      if (i == last) begin
        if (lp) begin
          i = 0;
        end else begin
          if (c <= cutoff) begin
            exp_q.push_back('{1, c, 0, 0, 0});
            done_cyc = c;
          end
          break;
        end
      end else begin
        i = (i + 1) % STEPS;
      end
    end
    busy_from = t0;
    busy_to   = (done_cyc >= 0) ? done_cyc : cutoff + 1;
  endtask

  task automatic wr(input int addr, input int f, input int p, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_func = 3'(f); wr_phase = 8'(p); wr_dwell = 16'(d);
    @(negedge clk);
    wr_en = 1'b0;
    m_func[addr] = f; m_phase[addr] = p; m_dwell[addr] = d;
  endtask

  task automatic run(input int last, input bit lp, input int run_len, input bit guard);
    @(negedge clk);
    t0 = cyc + 1;
    stop_cyc = t0 + run_len;
    plan(last, lp, lp ? stop_cyc : 32'h4000_0000);
    last_step = 3'(last); loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (guard) begin
      // Restart with a different last_step and overwrite an entry while busy.
      start = 1'b1; last_step = 3'(last ^ 5);
      wr_en = 1'b1; wr_addr = 3'(last); wr_func = 3'(m_func[last] + 1);
      wr_phase = 8'(m_phase[last] ^ 8'hA5); wr_dwell = 16'(m_dwell[last] + 3);
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
    end
    if (lp) begin
      while (cyc < stop_cyc) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_ld", 32'(dds_ld), 32'd0);
      check("stop_func_hold", 32'(func), 32'(last_f));
      check("stop_phase_hold", 32'(phaseControll), 32'(last_p));
      check("stop_idx_hold", 32'(step_idx), 32'(last_i));
    end else begin
      while (cyc <= done_cyc) @(negedge clk);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("run  last=%0d loop=%0d guard=%0d start=%0d", last, lp, guard, t0);
  endtask

  initial begin
    for (int i = 0; i < STEPS; i++) begin
      m_func[i] = 0; m_phase[i] = 0; m_dwell[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_func", 32'(func), 32'd0);
    check("rst_phase", 32'(phaseControll), 32'd0);
    check("rst_idx", 32'(step_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Single step.
    wr(0, 3, 5, 4);
    run(0, 1'b0, 0, 1'b0);

    // Three-step sweep, with start/write guards applied mid-run.
    wr(0, 1, 1, 2);
    wr(1, 2, 2, 0);
    wr(2, 7, 4, 3);
    run(2, 1'b0, 0, 1'b1);

    // Loop on the same table (also confirms the guarded write was dropped).
    run(2, 1'b1, 20, 1'b0);

    // start and stop together while idle.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check("start_stop_idle_busy", 32'(busy), 32'd0);

    // Randomized tables and runs.
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < STEPS; a++)
        wr(a, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 5));
      run($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(8, 30), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a dwell.
    wr(0, 5, 9, 12);
    @(negedge clk);
    t0 = cyc + 1;
    plan(0, 1'b0, t0 + 3);
    last_step = '0; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_func", 32'(func), 32'd0);
    check("async_phase", 32'(phaseControll), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_ld", 32'(dds_ld), 32'd0);
    check("async_idx", 32'(step_idx), 32'd0);
    check("async_done", 32'(done), 32'd0);
    for (int i = 0; i < STEPS; i++) begin
      m_func[i] = 0; m_phase[i] = 0; m_dwell[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("async_no_done", 32'(exp_q.size()), 32'd0);

    // Table must read back as cleared after reset.
    run(0, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
